// File: rtl/stickman_pkg.sv
// stickman_pkg
//   Shared types and constants for the StickmanRun player-motion unit.
//   - motion_state_t : vertical motion state of the sprite
//   - SCREEN_W/H     : visible VGA raster size
//   - DEF_*          : default sprite geometry and jump physics
package stickman_pkg;

    typedef enum logic [1:0] {
        GROUND  = 2'd0,
        RISING  = 2'd1,
        FALLING = 2'd2
    } motion_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [9:0] DEF_X_POS    = 10'd120;
    localparam logic [9:0] DEF_WIDTH    = 10'd16;
    localparam logic [9:0] DEF_HEIGHT   = 10'd32;
    localparam logic [9:0] DEF_GROUND_Y = 10'd400;
    localparam logic [7:0] DEF_JUMP_V   = 8'd12;
    localparam logic [7:0] DEF_GRAVITY  = 8'd1;
    localparam logic [7:0] DEF_MAX_FALL = 8'd15;

endpackage

// File: rtl/stickman_motion_edge_rise_detect.sv
// edge_rise_detect
//   Rising-edge detector: remembers the input from the previous Clk and
//   pulses for exactly one cycle when the input goes from 0 to 1.
//   Ports:
//     clk   - system clock
//     rst_n - asynchronous active-low reset (history cleared to 0)
//     sig   - level input, synchronous to clk
//     pulse - sig & ~sig_delayed
module edge_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic pulse
);

    logic sig_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig;
        end
    end

    // Pulse is combinational on the current level so an edge is usable in
    // the same cycle it arrives.
    assign pulse = sig & ~sig_d;

endmodule

// File: rtl/stickman_motion.sv
// stickman_motion
//   Player-sprite motion unit: keeps the stickman's feet row and jump state,
//   advances the jump physics once per video frame, and flags pixels that
//   fall inside the sprite box for the colour mapper.
//   Ports:
//     Clk         - 50 MHz system clock
//     Reset_n     - asynchronous active-low reset
//     frame_clk   - VGA vertical sync (synchronous to Clk); rising edge = frame tick
//     jump_key    - level, high while the jump key is held
//     DrawX/DrawY - current pixel column/row
//     is_stickman - current pixel lies inside the sprite box
//     Stick_Y     - current feet row (bottom row of the box)
//     airborne    - sprite is not standing on the ground
module stickman_motion
    import stickman_pkg::*;
#(
    parameter logic [9:0] X_POS    = DEF_X_POS,
    parameter logic [9:0] WIDTH    = DEF_WIDTH,
    parameter logic [9:0] HEIGHT   = DEF_HEIGHT,
    parameter logic [9:0] GROUND_Y = DEF_GROUND_Y,
    parameter logic [7:0] JUMP_V   = DEF_JUMP_V,
    parameter logic [7:0] GRAVITY  = DEF_GRAVITY,
    parameter logic [7:0] MAX_FALL = DEF_MAX_FALL
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       jump_key,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       is_stickman,
    output logic [9:0] Stick_Y,
    output logic       airborne
);

    // Parameter legality: apex must stay on screen, gravity must pull down,
    // and the fall cap must not be slower than the take-off speed.
    if (int'(JUMP_V) * (int'(JUMP_V) + 1) / 2 >= int'(GROUND_Y) - int'(HEIGHT)) begin : g_bad_apex
        $error("stickman_motion: jump apex would leave the top of the screen");
    end
    if (GRAVITY < 8'd1) begin : g_bad_gravity
        $error("stickman_motion: GRAVITY must be at least 1");
    end
    if (MAX_FALL < JUMP_V) begin : g_bad_max_fall
        $error("stickman_motion: MAX_FALL must be at least JUMP_V");
    end
    if (int'(GROUND_Y) >= SCREEN_H) begin : g_bad_ground
        $error("stickman_motion: GROUND_Y must lie inside the screen");
    end

    logic tick;
    logic key_edge;

    edge_rise_detect u_frame_edge (
        .clk   (Clk),
        .rst_n (Reset_n),
        .sig   (frame_clk),
        .pulse (tick)
    );

    edge_rise_detect u_key_edge (
        .clk   (Clk),
        .rst_n (Reset_n),
        .sig   (jump_key),
        .pulse (key_edge)
    );

    motion_state_t      state, state_n;
    logic signed [7:0]  velocity, velocity_n;
    logic [9:0]         stick_y_n;
    logic               jump_req, jump_req_n;
    logic               req_eff;
    logic signed [10:0] y_next;
    logic signed [7:0]  v_next;

    function automatic logic signed [7:0] clamp_fall(input logic signed [7:0] v);
        logic signed [7:0] cap;
        cap = $signed(MAX_FALL);
        return (v > cap) ? cap : v;
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= GROUND;
            velocity <= '0;
            Stick_Y  <= GROUND_Y;
            jump_req <= 1'b0;
        end else begin
            state    <= state_n;
            velocity <= velocity_n;
            Stick_Y  <= stick_y_n;
            jump_req <= jump_req_n;
        end
    end

    always_comb begin
        state_n    = state;
        velocity_n = velocity;
        stick_y_n  = Stick_Y;
        req_eff    = jump_req | key_edge;
        // A pending request lives only until the next frame tick.
        jump_req_n = tick ? 1'b0 : req_eff;
        y_next     = $signed({1'b0, Stick_Y}) + $signed({{3{velocity[7]}}, velocity});
        v_next     = velocity + $signed(GRAVITY);

        if (tick) begin
            case (state)
                GROUND: begin
                    // Take-off only loads the speed; the box moves next frame.
                    if (req_eff) begin
                        velocity_n = -$signed(JUMP_V);
                        state_n    = RISING;
                    end
                end
                RISING, FALLING: begin
                    if (y_next >= $signed({1'b0, GROUND_Y})) begin
                        stick_y_n  = GROUND_Y;
                        velocity_n = '0;
                        state_n    = GROUND;
                    end else begin
                        stick_y_n  = y_next[9:0];
                        velocity_n = clamp_fall(v_next);
                        state_n    = v_next[7] ? RISING : FALLING;
                    end
                end
                default: begin
                    state_n = GROUND;
                end
            endcase
        end
    end

    assign airborne = (state != GROUND);

    // Box test done in 11 bits; the top edge is written as
    // DrawY + HEIGHT > Stick_Y so nothing is ever subtracted.
    logic [10:0] x_ext, y_ext, sy_ext, x_lo, x_hi;
    logic        in_x, in_y;

    always_comb begin
        x_ext  = {1'b0, DrawX};
        y_ext  = {1'b0, DrawY};
        sy_ext = {1'b0, Stick_Y};
        x_lo   = {1'b0, X_POS};
        x_hi   = {1'b0, X_POS} + {1'b0, WIDTH} - 11'd1;
        in_x   = (x_ext >= x_lo) && (x_ext <= x_hi);
        in_y   = ((y_ext + {1'b0, HEIGHT}) > sy_ext) && (y_ext <= sy_ext);
    end

    assign is_stickman = in_x & in_y;

endmodule

// File: tb/tb_stickman_motion.sv
module tb_stickman_motion;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_clk;
    logic       key_a, key_b;
    logic [9:0] DrawX, DrawY;
    logic       is_a, is_b;
    logic [9:0] y_a, y_b;
    logic       air_a, air_b;

    always #5 Clk = ~Clk;

    // Default physics
    stickman_motion dut_a (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_clk   (frame_clk),
        .jump_key    (key_a),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .is_stickman (is_a),
        .Stick_Y     (y_a),
        .airborne    (air_a)
    );

    // Heavy gravity with a tighter fall cap
    stickman_motion #(
        .GRAVITY  (8'd4),
        .MAX_FALL (8'd12)
    ) dut_b (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_clk   (frame_clk),
        .jump_key    (key_b),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .is_stickman (is_b),
        .Stick_Y     (y_b),
        .airborne    (air_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: position, velocity, air flag, pending request, key level
    int mg[2]  = '{1, 4};
    int mmf[2] = '{15, 12};
    int my[2];
    int mv[2];
    bit mair[2];
    bit mreq[2];
    bit mkey[2];

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit ref_box(input int x, input int y, input int sy);
        return (x >= 120) && (x <= 135) && (y >= sy - 31) && (y <= sy);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            my[i] = 400; mv[i] = 0; mair[i] = 0; mreq[i] = 0; mkey[i] = 0;
        end
        key_a = 1'b0;
        key_b = 1'b0;
    endtask

    task automatic model_tick(input int i);
        int yn, vn;
        if (!mair[i]) begin
            if (mreq[i]) begin
                mv[i]   = -12;
                mair[i] = 1;
            end
        end else begin
            yn = my[i] + mv[i];
            if (yn >= 400) begin
                my[i] = 400; mv[i] = 0; mair[i] = 0;
            end else begin
                my[i] = yn;
                vn = mv[i] + mg[i];
                mv[i] = (vn > mmf[i]) ? mmf[i] : vn;
            end
        end
        mreq[i] = 0;
    endtask

    // Called at a falling edge; takes effect at the next rising edge.
    task automatic set_key(input int i, input bit v);
        if (v && !mkey[i]) mreq[i] = 1;
        mkey[i] = v;
        if (i == 0) key_a = v; else key_b = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic check_state(input string tag);
        int x, y;
        check({tag, "_y_a"}, int'(y_a), my[0]);
        check({tag, "_air_a"}, int'(air_a), int'(mair[0]));
        check({tag, "_y_b"}, int'(y_b), my[1]);
        check({tag, "_air_b"}, int'(air_b), int'(mair[1]));
        x = $urandom_range(110, 145);
        y = my[0] - 40 + $urandom_range(0, 50);
        DrawX = x[9:0]; DrawY = y[9:0];
        #1;
        check({tag, "_box_a"}, int'(is_a), int'(ref_box(x, y, my[0])));
        y = my[1] - 40 + $urandom_range(0, 50);
        DrawY = y[9:0];
        #1;
        check({tag, "_box_b"}, int'(is_b), int'(ref_box(x, y, my[1])));
    endtask

    // Enters and leaves on a falling edge; one frame tick plus one idle cycle.
    task automatic do_tick(input string tag);
        frame_clk = 1'b1;
        @(posedge Clk);
        model_tick(0);
        model_tick(1);
        @(negedge Clk);
        frame_clk = 1'b0;
        check_state(tag);
        @(negedge Clk);
    endtask

    initial begin
        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        DrawX     = '0;
        DrawY     = '0;
        model_reset();
        idle(3);
        check("reset_y_a", int'(y_a), 400);
        check("reset_air_a", int'(air_a), 0);
        check("reset_y_b", int'(y_b), 400);
        Reset_n = 1'b1;
        idle(2);

        // Standing still, no key
        for (int k = 0; k < 10; k++) do_tick("idle");
        DrawX = 10'd120; DrawY = 10'd369; #1;
        check("box_top_row", int'(is_a), 1);
        DrawY = 10'd368; #1;
        check("box_above_top", int'(is_a), 0);
        DrawX = 10'd136; DrawY = 10'd380; #1;
        check("box_right_of", int'(is_a), 0);
        idle(1);

        // Key pulse between ticks on both units
        set_key(0, 1); set_key(1, 1);
        idle(1);
        set_key(0, 0); set_key(1, 0);
        idle(1);
        for (int k = 0; k < 30; k++) begin
            do_tick("jump");
            if (k == 0) begin
                check("consume_y", int'(y_a), 400);
                check("consume_air", int'(air_a), 1);
            end
            if (k == 1)  check("first_move", int'(y_a), 388);
            if (k == 3)  check("heavy_y3", int'(y_b), 376);
            if (k == 12) check("apex_y", int'(y_a), 322);
            if (k == 26) begin
                check("landed_y", int'(y_a), 400);
                check("landed_air", int'(air_a), 0);
            end
        end

        // Key held for 40 ticks: exactly one jump
        set_key(0, 1);
        idle(1);
        for (int k = 0; k < 40; k++) begin
            do_tick("held");
            if (k == 26 || k == 39) check("held_no_rejump", int'(air_a), 0);
        end
        set_key(0, 0);
        idle(1);
        do_tick("release");
        check("released_ground", int'(air_a), 0);
        set_key(0, 1);
        idle(1);
        do_tick("repress");
        check("repress_jumps", int'(air_a), 1);
        set_key(0, 0);
        for (int k = 0; k < 30; k++) do_tick("repress_fly");

        // Edge on the tick cycle, then a press mid-flight
        set_key(0, 1);
        do_tick("same_cycle");
        check("same_cycle_air", int'(air_a), 1);
        check("same_cycle_y", int'(y_a), 400);
        set_key(0, 0);
        for (int k = 1; k < 30; k++) begin
            if (k == 5) set_key(0, 1);
            if (k == 7) set_key(0, 0);
            do_tick("mid_press");
            if (k == 26) check("no_double_jump", int'(air_a), 0);
        end

        // Randomised key activity against the model
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < 2; i++)
                if ($urandom_range(0, 3) == 0) set_key(i, !mkey[i]);
            if ($urandom_range(0, 3) != 0) idle($urandom_range(1, 3));
            do_tick("rand");
        end

        // Asynchronous reset mid-rise
        set_key(0, 0); set_key(1, 0);
        for (int k = 0; k < 40; k++) do_tick("settle");
        set_key(0, 1);
        idle(1);
        set_key(0, 0);
        for (int k = 0; k < 7; k++) do_tick("pre_reset");
        check("pre_reset_y", int'(y_a), 343);
        #1 Reset_n = 1'b0;
        #1;
        check("async_reset_y", int'(y_a), 400);
        check("async_reset_air", int'(air_a), 0);
        model_reset();
        idle(1);
        Reset_n = 1'b1;
        idle(2);
        do_tick("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
